// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared I2C widths, ACK levels, FSM state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] c_st_idle     = 3'd0;
    localparam logic [ST_W-1:0] c_st_addr     = 3'd1;
    localparam logic [ST_W-1:0] c_st_addr_ack = 3'd2;
    localparam logic [ST_W-1:0] c_st_wr_data  = 3'd3;
    localparam logic [ST_W-1:0] c_st_wr_ack   = 3'd4;
    localparam logic [ST_W-1:0] c_st_rd_data  = 3'd5;
    localparam logic [ST_W-1:0] c_st_rd_ack   = 3'd6;
    localparam logic [ST_W-1:0] c_st_ignore   = 3'd7;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : scl/sda synchroniser, optional majority glitch filter
//               (I2C_TARGET_GLITCH_FILTER_EN) and edge/START/STOP detection.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   w_scl_s;
    logic                   w_sda_s;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    // Idle bus is high, so reset to 1 to avoid phantom edges after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_filt;
    logic       r_sda_filt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync[SYNC_STAGES-1]};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync[SYNC_STAGES-1]};
            r_scl_filt <= maj3({r_scl_hist, r_scl_sync[SYNC_STAGES-1]});
            r_sda_filt <= maj3({r_sda_hist, r_sda_sync[SYNC_STAGES-1]});
        end
    end

    assign w_scl_s = r_scl_filt;
    assign w_sda_s = r_sda_filt;
`else
    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
        end
    end

    assign o_sda      = w_sda_s;
    assign o_scl_rise = w_scl_s & ~r_scl_prev;
    assign o_scl_fall = ~w_scl_s & r_scl_prev;
    assign o_start    = w_scl_s & r_sda_prev & ~w_sda_s;
    assign o_stop     = w_scl_s & ~r_sda_prev & w_sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target
// Description : Oversampling I2C target: address match, ACK, byte write
//               capture and byte read serialisation. Optional glitch filter
//               via I2C_TARGET_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h52,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_out,
    input  logic [I2C_DATA_W-1:0] tx_data,
    output logic                  tx_load,
    output logic [I2C_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  addr_match,
    output logic                  busy
);

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk        (clk),
        .reset      (reset),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    logic [ST_W-1:0]       r_state,    w_state_nxt;
    logic [3:0]            r_cnt,      w_cnt_nxt;
    logic [I2C_DATA_W-1:0] r_shift,    w_shift_nxt;
    logic [I2C_DATA_W-1:0] r_rx_data,  w_rx_data_nxt;
    logic                  r_sda_out,  w_sda_out_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  r_tx_load,  w_tx_load_nxt;
    logic                  r_am,       w_am_nxt;
    logic                  r_busy,     w_busy_nxt;
    logic                  r_rw,       w_rw_nxt;
    logic                  r_phase,    w_phase_nxt;
    logic [I2C_DATA_W-1:0] w_shift_in;

    assign w_shift_in = {r_shift[I2C_DATA_W-2:0], w_sda};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= 4'd0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_sda_out  <= 1'b1;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_am       <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_phase    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_sda_out  <= w_sda_out_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_load  <= w_tx_load_nxt;
            r_am       <= w_am_nxt;
            r_busy     <= w_busy_nxt;
            r_rw       <= w_rw_nxt;
            r_phase    <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_rx_data_nxt  = r_rx_data;
        w_sda_out_nxt  = r_sda_out;
        w_rx_valid_nxt = 1'b0;
        w_tx_load_nxt  = 1'b0;
        w_am_nxt       = r_am;
        w_busy_nxt     = r_busy;
        w_rw_nxt       = r_rw;
        w_phase_nxt    = r_phase;

        if (w_start) begin
            w_state_nxt   = c_st_addr;
            w_cnt_nxt     = 4'd0;
            w_sda_out_nxt = 1'b1;
            w_am_nxt      = 1'b0;
            w_busy_nxt    = 1'b1;
            w_phase_nxt   = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = c_st_idle;
            w_cnt_nxt     = 4'd0;
            w_sda_out_nxt = 1'b1;
            w_am_nxt      = 1'b0;
            w_busy_nxt    = 1'b0;
            w_phase_nxt   = 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                end
                c_st_addr: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_shift_in;
                        if (r_cnt == 4'd7) begin
                            w_cnt_nxt = 4'd0;
                            w_rw_nxt  = w_shift_in[0];
                            if (w_shift_in[I2C_DATA_W-1:1] == TARGET_ADDR) begin
                                w_state_nxt = c_st_addr_ack;
                                w_phase_nxt = 1'b0;
                            end else begin
                                w_state_nxt = c_st_ignore;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                end
                // phase 0: pull low on the fall ending bit 8; phase 1: release on the fall ending bit 9
                c_st_addr_ack, c_st_wr_ack: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_out_nxt = ACK;
                            w_am_nxt      = 1'b1;
                            w_phase_nxt   = 1'b1;
                        end else begin
                            w_phase_nxt   = 1'b0;
                            w_sda_out_nxt = 1'b1;
                            w_cnt_nxt     = 4'd0;
                            if (r_state == c_st_wr_ack || !r_rw) begin
                                w_state_nxt = c_st_wr_data;
                            end else begin
                                w_state_nxt   = c_st_rd_data;
                                w_shift_nxt   = {tx_data[I2C_DATA_W-2:0], 1'b0};
                                w_sda_out_nxt = tx_data[I2C_DATA_W-1];
                                w_tx_load_nxt = 1'b1;
                                w_cnt_nxt     = 4'd1;
                            end
                        end
                    end
                end
                c_st_wr_data: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_shift_in;
                        if (r_cnt == 4'd7) begin
                            w_rx_data_nxt  = w_shift_in;
                            w_rx_valid_nxt = 1'b1;
                            w_state_nxt    = c_st_wr_ack;
                            w_phase_nxt    = 1'b0;
                            w_cnt_nxt      = 4'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                end
                c_st_rd_data: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_sda_out_nxt = 1'b1;
                            w_state_nxt   = c_st_rd_ack;
                            w_phase_nxt   = 1'b0;
                            w_cnt_nxt     = 4'd0;
                        end else begin
                            w_sda_out_nxt = r_shift[I2C_DATA_W-1];
                            w_shift_nxt   = {r_shift[I2C_DATA_W-2:0], 1'b0};
                            w_cnt_nxt     = r_cnt + 4'd1;
                        end
                    end
                end
                c_st_rd_ack: begin
                    if (w_scl_rise) begin
                        if (w_sda == ACK) begin
                            w_phase_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = c_st_ignore;
                            w_sda_out_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        w_phase_nxt   = 1'b0;
                        w_state_nxt   = c_st_rd_data;
                        w_shift_nxt   = {tx_data[I2C_DATA_W-2:0], 1'b0};
                        w_sda_out_nxt = tx_data[I2C_DATA_W-1];
                        w_tx_load_nxt = 1'b1;
                        w_cnt_nxt     = 4'd1;
                    end
                end
                c_st_ignore: begin
                    w_sda_out_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt   = c_st_idle;
                    w_sda_out_nxt = 1'b1;
                end
            endcase
        end
    end

    assign sda_out    = r_sda_out;
    assign tx_load    = r_tx_load;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign addr_match = r_am;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i2c_target
// Description : Bit-banged I2C master driving i2c_target, checked against
//               a transaction table and a received-byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target;

    localparam int c_q = 4;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ack;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_in;
    logic       sda_out;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;

    assign sda_in = m_sda & sda_out;

    i2c_target #(
        .TARGET_ADDR (7'h52),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (m_scl),
        .sda_in     (sda_in),
        .sda_out    (sda_out),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         rx_cnt = 0;
    int         tl_cnt = 0;
    int         am_cnt = 0;
    int         rx_ptr = 0;
    logic [7:0] rx_log [64];
    logic [7:0] exp_rx [$];
    vec_t       vecs [6];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 64] = rx_data;
            rx_cnt++;
        end
        if (tx_load) tl_cnt++;
        if (addr_match) am_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mstart();
        m_sda = 1'b1; cyc(c_q);
        m_scl = 1'b1; cyc(2*c_q);
        m_sda = 1'b0; cyc(2*c_q);
        m_scl = 1'b0; cyc(c_q);
    endtask

    task automatic mstop();
        m_sda = 1'b0; cyc(c_q);
        m_scl = 1'b1; cyc(2*c_q);
        m_sda = 1'b1; cyc(2*c_q);
    endtask

    task automatic mwrite_bit(input logic b);
        m_sda = b;    cyc(c_q);
        m_scl = 1'b1; cyc(2*c_q);
        m_scl = 1'b0; cyc(c_q);
    endtask

    task automatic mread_bit(output logic b);
        m_sda = 1'b1; cyc(c_q);
        m_scl = 1'b1; cyc(c_q);
        b = sda_in;   cyc(c_q);
        m_scl = 1'b0; cyc(c_q);
    endtask

    task automatic mwrite_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) mwrite_bit(v[i]);
    endtask

    task automatic mread_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            mread_bit(b);
            v[i] = b;
        end
    endtask

    task automatic drain_rx();
        check("rx_pulses", rx_cnt - rx_ptr, exp_rx.size());
        while (exp_rx.size() > 0) begin
            check("rx_byte", rx_log[rx_ptr % 64], exp_rx.pop_front());
            rx_ptr++;
        end
        rx_ptr = rx_cnt;
    endtask

    task automatic run_xact(input vec_t v);
        int         tl0, am0;
        logic       b;
        logic [7:0] rb;
        logic [7:0] d [2];
        d[0] = v.d0;
        d[1] = v.d1;
        tl0 = tl_cnt;
        am0 = am_cnt;
        if (v.rw) tx_data = d[0];
        mstart();
        check("busy_after_start", busy, 1'b1);
        mwrite_byte({v.addr, v.rw});
        mread_bit(b);
        check("addr_ack", b, v.ack ? 1'b0 : 1'b1);
        if (!v.rw) begin
            for (int i = 0; i < v.n; i++) begin
                mwrite_byte(d[i]);
                if (v.ack) exp_rx.push_back(d[i]);
                mread_bit(b);
                check("data_ack", b, v.ack ? 1'b0 : 1'b1);
            end
        end else if (v.ack) begin
            for (int i = 0; i < v.n; i++) begin
                mread_byte(rb);
                check("rd_byte", rb, d[i]);
                if (i < v.n - 1) begin
                    tx_data = d[i+1];
                    mwrite_bit(1'b0);
                end else begin
                    mwrite_bit(1'b1);
                end
            end
            mread_byte(rb);
            check("ignore_after_nack", rb, 8'hFF);
        end
        mstop();
        cyc(6);
        check("busy_after_stop", busy, 1'b0);
        check("sda_released", sda_out, 1'b1);
        check("am_after_stop", addr_match, 1'b0);
        drain_rx();
        check("tx_loads", tl_cnt - tl0, (v.rw && v.ack) ? v.n : 0);
        check("am_seen", am_cnt > am0, v.ack);
        if (!v.rw && v.ack) check("rx_data", rx_data, d[v.n-1]);
    endtask

    initial begin
        logic       b;
        logic [7:0] rb;
        int         tl0;

        vecs[0] = '{addr: 7'h52, rw: 1'b0, n: 1, d0: 8'hAA, d1: 8'h00, ack: 1'b1};
        vecs[1] = '{addr: 7'h52, rw: 1'b1, n: 1, d0: 8'h70, d1: 8'h00, ack: 1'b1};
        vecs[2] = '{addr: 7'h4C, rw: 1'b0, n: 1, d0: 8'h33, d1: 8'h00, ack: 1'b0};
        vecs[3] = '{addr: 7'h52, rw: 1'b1, n: 2, d0: 8'h09, d1: 8'hC3, ack: 1'b1};
        vecs[4] = '{addr: 7'h52, rw: 1'b0, n: 2, d0: 8'h00, d1: 8'hFF, ack: 1'b1};
        vecs[5] = '{addr: 7'h53, rw: 1'b1, n: 1, d0: 8'h00, d1: 8'h00, ack: 1'b0};

        reset = 1'b0;
        cyc(5);
        check("rst_sda_out", sda_out, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_load", tx_load, 1'b0);
        check("rst_addr_match", addr_match, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        cyc(8);

        for (int i = 0; i < 6; i++) run_xact(vecs[i]);

        // repeated START: write 0x11, then re-address for a read
        tl0 = tl_cnt;
        mstart();
        mwrite_byte(8'hA4);
        mread_bit(b);
        check("rs_addr_ack", b, 1'b0);
        mwrite_byte(8'h11);
        exp_rx.push_back(8'h11);
        mread_bit(b);
        check("rs_data_ack", b, 1'b0);
        tx_data = 8'h5E;
        mstart();
        check("rs_am_cleared", addr_match, 1'b0);
        check("rs_busy", busy, 1'b1);
        mwrite_byte(8'hA5);
        mread_bit(b);
        check("rs_rd_addr_ack", b, 1'b0);
        check("rs_am_set", addr_match, 1'b1);
        mread_byte(rb);
        check("rs_rd_byte", rb, 8'h5E);
        mwrite_bit(1'b1);
        mstop();
        cyc(6);
        check("rs_rx_kept", rx_data, 8'h11);
        check("rs_tx_loads", tl_cnt - tl0, 1);
        drain_rx();

        // reset asserted while scl is high during the 4th data bit
        mstart();
        mwrite_byte(8'hA4);
        mread_bit(b);
        check("mr_addr_ack", b, 1'b0);
        mwrite_bit(1'b1);
        mwrite_bit(1'b0);
        mwrite_bit(1'b1);
        m_sda = 1'b0; cyc(c_q);
        m_scl = 1'b1; cyc(2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mr_sda_out", sda_out, 1'b1);
        check("mr_rx_data", rx_data, 8'h00);
        check("mr_rx_valid", rx_valid, 1'b0);
        check("mr_tx_load", tx_load, 1'b0);
        check("mr_addr_match", addr_match, 1'b0);
        check("mr_busy", busy, 1'b0);
        m_sda = 1'b1;
        cyc(6);
        reset = 1'b1;
        cyc(8);
        drain_rx();
        run_xact('{addr: 7'h52, rw: 1'b0, n: 1, d0: 8'h5A, d1: 8'h00, ack: 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder that sits directly downstream of the i2c master controller.
- Consumes the master's scl/sda lines and answers on the data line.
- Serves as the bench/system counterpart for master write and read transactions.
- Oversamples the bus in the system clock domain: detects START/STOP, matches a 7-bit address, ACKs, stores written bytes and serialises read bytes.

Parameters:
- TARGET_ADDR, 7'h52, 7-bit address this target answers to
- SYNC_STAGES, 2, synchroniser depth on scl_in/sda_in (minimum 2)

Ports:
- clk  input  1  system clock; must be at least 8x the scl rate
- reset  input  1  synchronous, active-low reset
- scl_in  input  1  bus clock from master
- sda_in  input  1  bus data as seen on the wire
- sda_out  output  1  open-drain emulation: 0 = pull low, 1 = release
- tx_data  input  8  byte to return on master reads
- tx_load  output  1  one-cycle pulse when tx_data is latched into the shifter
- rx_data  output  8  last byte written by master
- rx_valid  output  1  one-cycle pulse when rx_data updates
- addr_match  output  1  high from address ACK until STOP or repeated START
- busy  output  1  high between START and STOP

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, sda_out=1, rx_data=0, rx_valid=0, tx_load=0, addr_match=0, busy=0, bit counter=0. Reset mid-transfer aborts immediately; bus is released in the same cycle.
- Input path: SYNC_STAGES flops, then one "previous" register.
  - scl_rise/scl_fall/sda_rise/sda_fall are combinational compares of synced vs previous.
  - Total detection latency is SYNC_STAGES+1 clk.
- START: sda_fall while synced scl==1. STOP: sda_rise while scl==1. Both take priority over any bit event in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- START (any state, including repeated START) -> ADDR. Bit counter cleared, sda_out=1, addr_match=0, busy=1.
- STOP (any state) -> IDLE. sda_out=1, busy=0, addr_match=0.
- ADDR:
  - Shift sda on each scl_rise, MSB first, 8 bits (7 address bits + R/W).
  - After the 8th rise: address==TARGET_ADDR -> ADDR_ACK; otherwise -> IGNORE (sda_out stays 1).
- ADDR_ACK:
  - On the next scl_fall, drive sda_out=0 and set addr_match=1.
  - Release on the following scl_fall.
  - R/W=0 -> WR_DATA.
  - R/W=1 -> RD_DATA: in that same release cycle latch tx_data, pulse tx_load, and drive its MSB.
- WR_DATA:
  - 8 scl_rise samples.
  - On the 8th: rx_data <= shifted byte, rx_valid pulses for 1 clk, go to WR_ACK.
- WR_ACK: ACK is driven and released as in ADDR_ACK, then -> WR_DATA for the next byte. Unlimited bytes.
- RD_DATA:
  - sda_out changes only on scl_fall (next bit, MSB first).
  - After the 8th bit's scl_fall, release sda -> RD_ACK.
- RD_ACK: sample sda on scl_rise.
  - 0 (ACK) -> on the next scl_fall latch tx_data, pulse tx_load, drive MSB, -> RD_DATA.
  - 1 (NACK) -> IGNORE with sda released.
- IGNORE: sda_out=1; wait for STOP or START.
- scl_rise events in IDLE are ignored. sda changes while scl is low are never START/STOP.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter is inserted after the synchroniser on both scl and sda. Pulses of 1 clk are suppressed and detection latency becomes SYNC_STAGES+3 clk.
- Undefined: no filter; latency is SYNC_STAGES+1.

Decomposition:
- Shared package i2c_pkg: state enumeration constants (shared with the master FSM encoding style), I2C_ADDR_W=7, I2C_DATA_W=8, ACK=1'b0, NACK=1'b1.
- One sub-module, i2c_bus_sync: synchroniser, optional glitch filter, and edge/START/STOP detection.
- FSM and shifters stay in i2c_target.

Test Plan:
- Write 0x52+W, data 0xAA -> ACK (sda_out=0) on address and data bits; rx_data=0xAA with a single rx_valid pulse; busy falls after STOP.
- Read 0x52+R with tx_data=0x70, master NACK -> serialised bits 0,1,1,1,0,0,0,0; one tx_load pulse; IGNORE until STOP; sda_out=1 afterwards.
- Address 0x4C+W, data 0x33 -> no ACK (sda_out stays 1), no rx_valid, addr_match=0 throughout.
- Read 0x52+R, master ACKs byte 1 then NACKs byte 2 (tx_data 0x09, then 0xC3) -> two tx_load pulses; bytes 0x09 and 0xC3 appear on sda_out.
- Repeated START after a write of 0x11, then 0x52+R -> ADDR re-entered, read proceeds; rx_data keeps 0x11.
- reset asserted low mid WR_DATA (4th bit) -> next clk all outputs at reset values; a following complete write of 0x5A succeeds.
